// File: rtl/ext_mem_arbiter.sv
// Two-requester tile-burst arbiter: 16-word loads/stores from the d and i sides onto one ext bus.
// Define EXT_ARB_RR_EN for round-robin arbitration; the default build uses fixed d-first priority.
module ext_mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        dReq,
    input  logic        iReq,
    input  logic        dWr,
    input  logic [25:0] dBase,
    input  logic [25:0] iBase,
    input  logic [31:0] dWrData,
    output logic        dGnt,
    output logic        iGnt,
    output logic        dDone,
    output logic        iDone,
    output logic [3:0]  wIdx,
    output logic [31:0] rdData,
    output logic        rdValid,
    output logic [31:0] extAddr,
    output logic [31:0] extDataOut,
    input  logic [31:0] extDataIn,
    output logic        extOE,
    output logic        extWR,
    input  logic        extNotReady,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;      // 1 = i side owns the burst
    logic        dir_q, dir_d;          // 1 = store
    logic [25:0] base_q, base_d;
    logic [3:0]  cnt_q, cnt_d;          // address word counter
    logic [3:0]  rd_idx_q, rd_idx_d;    // index of the word presented on rdData
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        pick_i;

`ifdef EXT_ARB_RR_EN
    logic prio_i_q, prio_i_d;           // 1 = i side wins a tie

    assign pick_i = iReq && (!dReq || prio_i_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_i_q <= 1'b0;
        end else begin
            prio_i_q <= prio_i_d;
        end
    end

    always_comb begin
        prio_i_d = prio_i_q;
        if (state_q == DONE) begin
            prio_i_d = !owner_q;
        end
    end
`else
    assign pick_i = iReq && !dReq;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dir_d      = dir_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (dReq || iReq) begin
                    owner_d = pick_i;
                    base_d  = pick_i ? iBase : dBase;
                    dir_d   = pick_i ? 1'b0 : dWr;
                    cnt_d   = 4'd0;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = XFER;
            XFER: begin
                if (!extNotReady) begin
                    if (!dir_q) begin
                        rd_data_d  = extDataIn;
                        rd_valid_d = 1'b1;
                        rd_idx_d   = cnt_q;
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            dir_q      <= 1'b0;
            base_q     <= 26'd0;
            cnt_q      <= 4'd0;
            rd_idx_q   <= 4'd0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dir_q      <= dir_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    logic in_burst;
    logic in_xfer;

    assign in_burst = (state_q == SETUP) || (state_q == XFER);
    assign in_xfer  = (state_q == XFER);

    assign busy    = (state_q != IDLE);
    assign dGnt    = in_burst && !owner_q;
    assign iGnt    = in_burst && owner_q;
    assign dDone   = (state_q == DONE) && !owner_q;
    assign iDone   = (state_q == DONE) && owner_q;
    assign extOE   = in_xfer && !dir_q;
    assign extWR   = in_xfer && dir_q;
    assign rdData  = rd_data_q;
    assign rdValid = rd_valid_q;

    assign extDataOut = (in_xfer && dir_q) ? dWrData : 32'd0;

    // A load word is strobed one cycle after its access, when the counter has already moved on,
    // so wIdx reports the strobed word's index during rdValid and the address counter otherwise.
    assign wIdx = rd_valid_q ? rd_idx_q : cnt_q;

    always_comb begin
        extAddr = 32'd0;
        case (state_q)
            SETUP:   extAddr = {base_q, 6'b0};
            XFER:    extAddr = {base_q, cnt_q, 2'b00};
            default: extAddr = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Self-checking bench for ext_mem_arbiter: directed burst table, reset abort, randomized bursts.
// Expected bus activity is generated per word of each burst from the arbitration rules.
module tb_ext_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        dReq, iReq, dWr;
    logic [25:0] dBase, iBase;
    logic [31:0] dWrData;
    logic        dGnt, iGnt, dDone, iDone;
    logic [3:0]  wIdx;
    logic [31:0] rdData;
    logic        rdValid;
    logic [31:0] extAddr, extDataOut, extDataIn;
    logic        extOE, extWR, extNotReady;
    logic        busy;

    ext_mem_arbiter dut (
        .clock(clock), .reset(reset), .dReq(dReq), .iReq(iReq), .dWr(dWr),
        .dBase(dBase), .iBase(iBase), .dWrData(dWrData), .dGnt(dGnt), .iGnt(iGnt),
        .dDone(dDone), .iDone(iDone), .wIdx(wIdx), .rdData(rdData), .rdValid(rdValid),
        .extAddr(extAddr), .extDataOut(extDataOut), .extDataIn(extDataIn), .extOE(extOE),
        .extWR(extWR), .extNotReady(extNotReady), .busy(busy)
    );

    always #5 clock = ~clock;

`ifdef EXT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int    checks = 0;
    int    errors = 0;
    string cur = "init";
    bit    last_owner_i = 1'b1;   // owner of the last completed burst; 1 gives d the next tie

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s @%0t: got %h expected %h", cur, name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        cur = tag;
        chk("busy", 32'(busy), 32'd0);
        chk("grants", 32'({dGnt, iGnt}), 32'd0);
        chk("dones", 32'({dDone, iDone}), 32'd0);
        chk("rdValid", 32'(rdValid), 32'd0);
        chk("strobes", 32'({extOE, extWR}), 32'd0);
        chk("extAddr", extAddr, 32'd0);
        chk("extDataOut", extDataOut, 32'd0);
        chk("rdData", rdData, 32'd0);
        chk("wIdx", 32'(wIdx), 32'd0);
    endtask

    // Rule-level arbitration: a lone requester wins; ties go to d (fixed) or to the non-owner (rr).
    function automatic bit model_pick_i(input bit rd, input bit ri);
        if (!ri) return 1'b0;
        if (!rd) return 1'b1;
        if (RR) return !last_owner_i;
        return 1'b0;
    endfunction

    // Drives one full burst from IDLE back to IDLE and checks every cycle of it.
    task automatic run_burst(input string name, input bit rq_d, input bit rq_i, input bit wr,
                             input logic [25:0] bd, input logic [25:0] bi, input int stall_at,
                             input int stall_len, input bit rnd, input bit drop, input bit exp_i);
        logic [25:0] base;
        bit          dir;
        bit          rv_exp;
        logic [31:0] rd_exp;
        int          rd_k;
        int          n;
        cur  = name;
        base = exp_i ? bi : bd;
        dir  = exp_i ? 1'b0 : wr;
        dReq = rq_d; iReq = rq_i; dWr = wr; dBase = bd; iBase = bi;
        extNotReady = 1'b0; dWrData = 32'd0;
        #1;
        chk("idle busy", 32'(busy), 32'd0);
        step();
        if (drop) begin
            dReq = 1'b0;
            iReq = 1'b0;
        end
        #1;
        chk("setup grants", 32'({dGnt, iGnt}), 32'({!exp_i, exp_i}));
        chk("setup extAddr", extAddr, {base, 6'b0});
        chk("setup strobes", 32'({extOE, extWR}), 32'd0);
        chk("setup busy", 32'(busy), 32'd1);
        step();
        rv_exp = 1'b0; rd_exp = 32'd0; rd_k = 0;
        for (int k = 0; k < 16; k++) begin
            n = (k == stall_at) ? stall_len : 0;
            if (rnd && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
            for (int s = 0; s <= n; s++) begin
                extNotReady = (s < n);
                extDataIn   = $urandom;
                dWrData     = dir ? k * 32'h1111_1111 : $urandom;
                #1;
                chk("xfer grants", 32'({dGnt, iGnt}), 32'({!exp_i, exp_i}));
                chk("xfer extAddr", extAddr, {base, 4'(k), 2'b00});
                chk("xfer strobes", 32'({extOE, extWR}), 32'({!dir, dir}));
                chk("xfer extDataOut", extDataOut, dir ? k * 32'h1111_1111 : 32'd0);
                chk("xfer rdValid", 32'(rdValid), 32'(rv_exp));
                chk("xfer dones", 32'({dDone, iDone}), 32'd0);
                if (rv_exp) begin
                    chk("xfer rdData", rdData, rd_exp);
                    chk("xfer rd wIdx", 32'(wIdx), 32'(rd_k));
                end
                if (dir) chk("xfer st wIdx", 32'(wIdx), 32'(k));
                rv_exp = !extNotReady && !dir;
                if (rv_exp) begin
                    rd_exp = extDataIn;
                    rd_k   = k;
                end
                step();
            end
        end
        extNotReady = 1'b0;
        #1;
        chk("done pulse", 32'({dDone, iDone}), 32'({!exp_i, exp_i}));
        chk("done grants", 32'({dGnt, iGnt}), 32'd0);
        chk("done strobes", 32'({extOE, extWR}), 32'd0);
        chk("done rdValid", 32'(rdValid), 32'(rv_exp));
        if (rv_exp) begin
            chk("done rdData", rdData, rd_exp);
            chk("done rd wIdx", 32'(wIdx), 32'(rd_k));
        end
        step();
        chk("post busy", 32'(busy), 32'd0);
        chk("post dones", 32'({dDone, iDone}), 32'd0);
        chk("post rdValid", 32'(rdValid), 32'd0);
        chk("post wIdx", 32'(wIdx), 32'd0);
        last_owner_i = exp_i;
    endtask

    typedef struct {
        string       name;
        bit          rq_d, rq_i, wr;
        logic [25:0] bd, bi;
        int          stall_at, stall_len;
        bit          exp_i_fx, exp_i_rr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"i load",       0, 1, 0, 26'h0000000, 26'h0000040, -1, 0, 1, 1};
        vecs[1] = '{"d store",      1, 0, 1, 26'h0000123, 26'h0000000, -1, 0, 0, 0};
        vecs[2] = '{"i stall",      0, 1, 0, 26'h0000000, 26'h0000040,  3, 5, 1, 1};
        vecs[3] = '{"contend 1",    1, 1, 0, 26'h0002000, 26'h0003000, -1, 0, 0, 0};
        vecs[4] = '{"contend 2",    1, 1, 0, 26'h0002000, 26'h0003000, -1, 0, 0, 1};
        vecs[5] = '{"contend 3",    1, 1, 0, 26'h0002000, 26'h0003000, -1, 0, 0, 0};
        vecs[6] = '{"contend st",   1, 1, 1, 26'h3FFFFFF, 26'h1555555, 15, 2, 0, 1};

        reset = 1'b0;
        dReq = 0; iReq = 0; dWr = 0; dBase = 0; iBase = 0; dWrData = 0;
        extDataIn = 0; extNotReady = 0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        foreach (vecs[v]) begin
            run_burst(vecs[v].name, vecs[v].rq_d, vecs[v].rq_i, vecs[v].wr, vecs[v].bd,
                      vecs[v].bi, vecs[v].stall_at, vecs[v].stall_len, 1'b0, 1'b0,
                      RR ? vecs[v].exp_i_rr : vecs[v].exp_i_fx);
        end

        // Abort a store burst at word 7 with an asynchronous reset.
        cur = "abort";
        dReq = 1; iReq = 0; dWr = 1; dBase = 26'h0000155;
        step();
        step();
        for (int k = 0; k < 7; k++) begin
            dWrData = k * 32'h1111_1111;
            step();
        end
        chk("pre-reset wIdx", 32'(wIdx), 32'd7);
        chk("pre-reset extAddr", extAddr, {26'h0000155, 4'd7, 2'b00});
        reset = 1'b0;
        #1;
        chk_all_zero("async reset");
        dReq = 0;
        repeat (3) begin
            step();
            chk("no done in reset", 32'({dDone, iDone}), 32'd0);
        end
        reset = 1'b1;
        last_owner_i = 1'b1;
        run_burst("post-reset", 1, 1, 1, 26'h0000200, 26'h0000300, -1, 0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            int          rq;
            bit          rd, ri, pk;
            logic [25:0] bd, bi;
            repeat ($urandom_range(0, 2)) begin
                dReq = 0; iReq = 0;
                step();
                cur = "gap";
                chk("gap busy", 32'(busy), 32'd0);
            end
            rq = $urandom_range(1, 3);
            rd = rq[0];
            ri = rq[1];
            bd = 26'($urandom);
            bi = 26'($urandom);
            pk = model_pick_i(rd, ri);
            run_burst($sformatf("rand %0d", r), rd, ri, 1'($urandom), bd, bi, -1, 0, 1'b1,
                      1'($urandom), pk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_mem_arbiter.md
EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have ports dReq/iReq, input, 1 each, tile transfer request from the data-tile side (d) and the instruction-tile side (i).
REQ-004 SHALL have port dWr, input, 1, data-side direction: 1 = tile store, 0 = tile load; the i-side only loads.
REQ-005 SHALL have ports dBase/iBase, input, 26 each, tile base address bits [31:6].
REQ-006 SHALL have port dWrData, input, 32, store word for the current wIdx.
REQ-007 SHALL have ports dGnt/iGnt, output, 1 each, high for the whole burst owned by that side.
REQ-008 SHALL have ports dDone/iDone, output, 1 each, one-cycle burst-complete pulse.
REQ-009 SHALL have port wIdx, output, 4, current word index within the tile.
REQ-010 SHALL have ports rdData (output, 32) and rdValid (output, 1): load word and its one-cycle strobe, qualified by wIdx and the grant.
REQ-011 SHALL have ports extAddr (output, 32), extDataOut (output, 32), extDataIn (input, 32), extOE (output, 1), extWR (output, 1), extNotReady (input, 1): external memory bus.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, SETUP, XFER, DONE.
REQ-014 IDLE: if dReq or iReq is high, SHALL latch the winner, its base and its direction (dWr for d, 0 for i), clear wIdx and go to SETUP. Otherwise SHALL stay in IDLE.
REQ-015 SETUP: SHALL assert the winner's grant, drive extAddr = {base, 6'b0}, and go to XFER next cycle. extOE and extWR stay low.
REQ-016 XFER: SHALL drive extAddr = {base, wIdx, 2'b00}, extOE = !dir and extWR = dir. extDataOut SHALL equal dWrData for stores and 0 for loads.
REQ-017 XFER: a cycle with extNotReady=0 SHALL complete one word. For a load, it SHALL register rdData = extDataIn and pulse rdValid on the next cycle with wIdx of that word. wIdx SHALL then increment.
REQ-018 XFER: a cycle with extNotReady=1 SHALL hold wIdx, address and strobes, and SHALL NOT pulse rdValid.
REQ-019 On completion of word 15, wIdx SHALL wrap to 0 and the state SHALL go to DONE. No 17th access is issued.
REQ-020 DONE: SHALL deassert extOE and extWR, pulse the owner's done output for exactly one cycle, drop the grant, and return to IDLE.
REQ-021 Deassertion of the owner's request mid-burst SHALL be ignored; the burst always runs 16 words.
REQ-022 Requests arriving during a burst SHALL be held pending and arbitrated in the IDLE following DONE. Minimum gap between bursts is one IDLE cycle.
REQ-023 When both requests are high in IDLE, the winner SHALL be chosen per REQ-027/028.
REQ-024 At most one grant SHALL be high in any cycle, and extOE and extWR SHALL never be high together.

Reset
REQ-025 While reset is low, SHALL asynchronously force state IDLE and wIdx 0. All outputs SHALL be 0: grants, dones, rdValid, extOE, extWR, extAddr, extDataOut, rdData, busy.
REQ-026 Reset asserted mid-burst SHALL abort the burst with no done pulse. After release, the block SHALL arbitrate from IDLE with a fixed-priority start (d first).

Configuration
REQ-027 With EXT_ARB_RR_EN defined, SHALL use round-robin arbitration: after each completed burst, priority goes to the side that did not own it. After reset, the d side has priority.
REQ-028 Without EXT_ARB_RR_EN, SHALL use fixed priority: d always wins ties, and i is served only when dReq is low in IDLE.

Verification
REQ-029 Load: iReq=1, iBase=26'h0000040, extNotReady=0 -> iGnt for 17 cycles (SETUP + 16), extAddr 0x1000..0x103C step 4, 16 rdValid pulses, wIdx 0..15, one iDone.
REQ-030 Store: dReq=1, dWr=1, dWrData=wIdx*0x11111111 -> extWR high 16 XFER cycles, extDataOut tracks wIdx, extOE stays 0, one dDone.
REQ-031 Stall: extNotReady=1 on cycles with wIdx=3 for 5 cycles -> extAddr holds base+0x0C, no rdValid during the stall, burst finishes 5 cycles later.
REQ-032 Contention: dReq and iReq held high -> fixed build gives dGnt on every burst; EXT_ARB_RR_EN build alternates dGnt, iGnt, dGnt.
REQ-033 Reset during a burst at wIdx=7 -> all outputs 0 immediately, no done pulse; a new request after release starts at wIdx=0.
